// File: rtl/reorder_buffer.sv
// In-order commit ROB; `ROB_WB_BYPASS_EN adds a same-cycle writeback view to rob_valid/rob_value.
// Latency: done entry retires on the next edge, 1/cycle. Backpressure: issue_ready low when full or flushing; rdy low freezes all.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_is_store,
    input  logic                      issue_is_branch,
    input  logic                      issue_pred_taken,
    input  logic [XLEN-1:0]           issue_pc,
    output logic                      issue_ready,
    output logic [TAG_W-1:0]          issue_tag,
    input  logic                      wb_valid,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic [XLEN-1:0]           wb_value,
    input  logic                      wb_taken,
    output logic [ROB_DEPTH-1:0]      rob_valid,
    output logic [ROB_DEPTH*XLEN-1:0] rob_value,
    output logic                      commit_valid,
    output logic [TAG_W-1:0]          commit_tag,
    output logic [4:0]                commit_rd,
    output logic [XLEN-1:0]           commit_value,
    output logic                      commit_store,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT  = 1;
    localparam logic [TAG_W-1:0] ONE_TAG  = 1;
    localparam logic [XLEN-1:0]  FOUR     = 4;

    logic [ROB_DEPTH-1:0] busy_q, done_q;
    logic [ROB_DEPTH-1:0] is_store_q, is_branch_q, pred_q, taken_q;
    logic [4:0]           rd_q    [ROB_DEPTH];
    logic [XLEN-1:0]      pc_q    [ROB_DEPTH];
    logic [XLEN-1:0]      value_q [ROB_DEPTH];
    logic [TAG_W-1:0]     head_q, tail_q;
    logic [TAG_W:0]       count_q;

    logic issue_fire, wb_accept, wb_take, retire, mispredict;

    assign issue_ready = (count_q != FULL_CNT) && !flush;
    assign issue_tag   = tail_q;
    assign retire      = (count_q != '0) && done_q[head_q];
    assign mispredict  = retire && is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    assign issue_fire  = rdy && issue_valid && issue_ready && !mispredict;
    assign wb_accept   = wb_valid && busy_q[wb_tag] && !done_q[wb_tag];
    // A mispredict retire wipes the window, so a writeback landing on that edge is discarded.
    assign wb_take     = rdy && wb_accept && !mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            flush        <= 1'b0;
            if (rdy) begin
                if (retire) begin
                    commit_valid <= 1'b1;
                    commit_tag   <= head_q;
                    commit_rd    <= rd_q[head_q];
                    commit_value <= value_q[head_q];
                    commit_store <= is_store_q[head_q];
                end
                if (mispredict) begin
                    flush    <= 1'b1;
                    flush_pc <= taken_q[head_q] ? value_q[head_q] : pc_q[head_q] + FOUR;
                    busy_q   <= '0;
                    done_q   <= '0;
                    head_q   <= '0;
                    tail_q   <= '0;
                    count_q  <= '0;
                end else begin
                    if (issue_fire) begin
                        busy_q[tail_q] <= 1'b1;
                        done_q[tail_q] <= 1'b0;
                        tail_q         <= tail_q + ONE_TAG;
                    end
                    if (wb_take)
                        done_q[wb_tag] <= 1'b1;
                    if (retire) begin
                        busy_q[head_q] <= 1'b0;
                        done_q[head_q] <= 1'b0;
                        head_q         <= head_q + ONE_TAG;
                    end
                    if (issue_fire && !retire)
                        count_q <= count_q + ONE_CNT;
                    else if (!issue_fire && retire)
                        count_q <= count_q - ONE_CNT;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through busy/done.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            rd_q[tail_q]        <= issue_rd;
            is_store_q[tail_q]  <= issue_is_store;
            is_branch_q[tail_q] <= issue_is_branch;
            pred_q[tail_q]      <= issue_pred_taken;
            pc_q[tail_q]        <= issue_pc;
        end
        if (wb_take) begin
            value_q[wb_tag] <= wb_value;
            taken_q[wb_tag] <= wb_taken;
        end
    end

    for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_bcast
`ifdef ROB_WB_BYPASS_EN
        logic hit;
        assign hit = wb_take && (wb_tag == TAG_W'(i));
        assign rob_valid[i] = (busy_q[i] & done_q[i]) | hit;
        assign rob_value[i*XLEN +: XLEN] = hit ? wb_value : value_q[i];
`else
        assign rob_valid[i] = busy_q[i] & done_q[i];
        assign rob_value[i*XLEN +: XLEN] = value_q[i];
`endif
    end

endmodule
